// File: rtl/isp_uart_pkg.sv
// Shared constants and state encodings for the ISP command receiver.
// Used by the 8N1 receiver and the frame parser.
package isp_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    P_SYNC,
    P_CMD,
    P_ARG,
    P_CHK
  } p_state_e;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling,
// one-cycle byte strobe and frame-error pulse.
module uart_rx_8n1
  import isp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic      sync1_q, sync2_q, prev_q;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       err_q, err_d;
  logic       rx_s, fall;

  assign rx_s = sync2_q;
  assign fall = prev_q & ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    err_d       = err_q;
    o_byte_vld  = 1'b0;
    o_frame_err = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // line back high at mid start bit: treat as a glitch
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (err_q) begin
          if (rx_s) begin
            err_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            o_byte_vld = 1'b1;
            state_d    = RX_IDLE;
          end else begin
            o_frame_err = 1'b1;
            err_d       = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign o_byte = sh_q;
  assign o_busy = (state_q != RX_IDLE);

endmodule

// File: rtl/isp_cmd_rx.sv
// ISP command receiver: parses A5/CMD/ARG/CHK frames from the UART
// and presents the command on a valid/ready output.
module isp_cmd_rx
  import isp_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic [7:0] o_cmd,
  output logic [7:0] o_arg,
  output logic       o_frame_err,
  output logic       o_chk_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic       byte_vld, frame_err, rx_busy, good;
  logic [7:0] rx_byte;

  p_state_e   p_q, p_d;
  logic [7:0] cmd_buf_q, cmd_buf_d, arg_buf_q, arg_buf_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d;
  logic [TW-1:0] to_q, to_d;
  logic       valid_q, valid_d;
  logic       chk_err_q, chk_err_d;
  logic       ovr_q, ovr_d;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .i_rx       (i_rx),
    .o_byte_vld (byte_vld),
    .o_byte     (rx_byte),
    .o_frame_err(frame_err),
    .o_busy     (rx_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q       <= P_SYNC;
      cmd_buf_q <= '0;
      arg_buf_q <= '0;
      cmd_q     <= '0;
      arg_q     <= '0;
      to_q      <= '0;
      valid_q   <= 1'b0;
      chk_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      p_q       <= p_d;
      cmd_buf_q <= cmd_buf_d;
      arg_buf_q <= arg_buf_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      to_q      <= to_d;
      valid_q   <= valid_d;
      chk_err_q <= chk_err_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    p_d       = p_q;
    cmd_buf_d = cmd_buf_q;
    arg_buf_d = arg_buf_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    valid_d   = valid_q;
    chk_err_d = 1'b0;
    ovr_d     = 1'b0;
    good      = 1'b0;

    if (p_q == P_SYNC || byte_vld) to_d = '0;
    else                           to_d = to_q + TW'(1);

    unique case (p_q)
      P_SYNC: if (byte_vld && rx_byte == SYNC_BYTE) p_d = P_CMD;
      P_CMD: if (byte_vld) begin
        cmd_buf_d = rx_byte;
        p_d       = P_ARG;
      end
      P_ARG: if (byte_vld) begin
        arg_buf_d = rx_byte;
        p_d       = P_CHK;
      end
      P_CHK: if (byte_vld) begin
        p_d = P_SYNC;
        if (rx_byte == (cmd_buf_q ^ arg_buf_q)) good = 1'b1;
        else                                    chk_err_d = 1'b1;
      end
    endcase

    // abandon a partial frame on a line error or inter-byte timeout
    if (p_q != P_SYNC &&
        (frame_err || (!byte_vld && to_q == TO_LAST)))
      p_d = P_SYNC;

    if (valid_q && i_cmd_ready) valid_d = 1'b0;
    if (good) begin
      if (!valid_q || i_cmd_ready) begin
        cmd_d   = cmd_buf_q;
        arg_d   = arg_buf_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_cmd_valid = valid_q;
  assign o_cmd       = cmd_q;
  assign o_arg       = arg_q;
  assign o_frame_err = frame_err;
  assign o_chk_err   = chk_err_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = rx_busy | (p_q != P_SYNC);

endmodule

// File: tb/tb_isp_cmd_rx.sv
// Self-checking bench for isp_cmd_rx: directed frames plus
// randomized frames checked against a frame-level reference model.
module tb_isp_cmd_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_rx;
  logic       i_cmd_ready;
  logic       o_cmd_valid;
  logic [7:0] o_cmd, o_arg;
  logic       o_frame_err, o_chk_err, o_overrun, o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt = 0, ce_cnt = 0, ov_cnt = 0, sb_cnt = 0, acc_cnt = 0;
  logic [15:0] exp_q[$];

  isp_cmd_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx       (i_rx),
    .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready),
    .o_cmd      (o_cmd),
    .o_arg      (o_arg),
    .o_frame_err(o_frame_err),
    .o_chk_err  (o_chk_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop = 1'b1);
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = stop;
    tick(CPB);
    i_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c,
                            input logic [7:0] a,
                            input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(k);
  endtask

  task automatic ready_pulse();
    i_cmd_ready = 1'b1;
    tick(1);
    i_cmd_ready = 1'b0;
  endtask

  // pulse counting and accept checking, sampled mid low phase
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (o_frame_err) fe_cnt++;
      if (o_chk_err) ce_cnt++;
      if (o_overrun) ov_cnt++;
      if (dut.u_rx.o_byte_vld) sb_cnt++;
      if (o_cmd_valid && i_cmd_ready) begin
        acc_cnt++;
        check("acc_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          check("acc_data", {o_cmd, o_arg}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int c0, f0, o0, s0, a0, exp_bad, n_good;
    logic [7:0] c, a, k, nb;
    logic stable;

    reset = 1'b1;
    i_rx = 1'b1;
    i_cmd_ready = 1'b0;
    tick(5);
    check("rst_valid", o_cmd_valid, 0);
    check("rst_cmdarg", {o_cmd, o_arg}, 0);
    check("rst_flags", {o_frame_err, o_chk_err, o_overrun, o_busy}, 0);
    reset = 1'b0;
    tick(5);

    // good frame, held until accepted
    send_frame(8'h03, 8'h7F, 8'h7C);
    tick(4);
    check("good_valid", o_cmd_valid, 1);
    check("good_cmdarg", {o_cmd, o_arg}, 16'h037F);
    stable = 1'b1;
    repeat (100) begin
      tick(1);
      if (!o_cmd_valid || {o_cmd, o_arg} != 16'h037F) stable = 1'b0;
    end
    check("good_hold", stable, 1);
    exp_q.push_back(16'h037F);
    ready_pulse();
    check("good_clear", o_cmd_valid, 0);

    // bad checksum then good frame
    c0 = ce_cnt;
    send_frame(8'h03, 8'h7F, 8'h00);
    tick(4);
    check("badchk_pulse", ce_cnt - c0, 1);
    check("badchk_valid", o_cmd_valid, 0);
    send_frame(8'h01, 8'h02, 8'h03);
    tick(4);
    check("after_bad_valid", o_cmd_valid, 1);
    check("after_bad_cmd", o_cmd, 8'h01);
    exp_q.push_back(16'h0102);
    ready_pulse();

    // glitch reject
    s0 = sb_cnt;
    i_rx = 1'b0;
    tick(8);
    i_rx = 1'b1;
    tick(3 * CPB);
    check("glitch_strobe", sb_cnt - s0, 0);
    check("glitch_busy", o_busy, 0);

    // framing error mid-frame resyncs parser
    f0 = fe_cnt;
    c0 = ce_cnt;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h3C, 1'b0);
    tick(2 * CPB);
    check("fe_pulse", fe_cnt - f0, 1);
    send_byte(8'h7F);
    send_byte(8'h7C);
    tick(4);
    check("fe_resync_valid", o_cmd_valid, 0);
    check("fe_resync_chk", ce_cnt - c0, 0);

    // overrun with ready low
    o0 = ov_cnt;
    send_frame(8'h11, 8'h22, 8'h33);
    send_frame(8'h44, 8'h55, 8'h11);
    tick(4);
    check("ovr_pulse", ov_cnt - o0, 1);
    check("ovr_valid", o_cmd_valid, 1);
    check("ovr_keep", {o_cmd, o_arg}, 16'h1122);
    exp_q.push_back(16'h1122);
    ready_pulse();

    // accept coinciding with completion of the next frame
    send_frame(8'h66, 8'h77, 8'h11);
    tick(4);
    check("coin_first", {o_cmd_valid, o_cmd, o_arg}, 17'h16677);
    exp_q.push_back(16'h6677);
    exp_q.push_back(16'h8899);
    send_byte(8'hA5);
    send_byte(8'h88);
    send_byte(8'h99);
    fork
      send_byte(8'h11);
      begin
        int n;
        n = 0;
        while (!dut.u_rx.o_byte_vld && n < CPB * 12) begin
          @(negedge clk);
          n++;
        end
        check("coin_strobe_seen", 32'(n < CPB * 12), 1);
        #1 i_cmd_ready = 1'b1;
        @(posedge clk);
        #1 i_cmd_ready = 1'b0;
      end
    join
    tick(4);
    check("coin_valid", o_cmd_valid, 1);
    check("coin_cmdarg", {o_cmd, o_arg}, 16'h8899);
    check("coin_no_ovr", ov_cnt - o0, 1);
    ready_pulse();

    // inter-byte timeout
    c0 = ce_cnt;
    send_byte(8'hA5);
    send_byte(8'h03);
    tick(TOB * CPB);
    tick(2);
    check("to_busy", o_busy, 0);
    send_byte(8'h7F);
    send_byte(8'h7C);
    tick(4);
    check("to_valid", o_cmd_valid, 0);
    check("to_chk", ce_cnt - c0, 0);

    // reset mid-byte with a command held
    send_frame(8'h09, 8'h0A, 8'h03);
    tick(4);
    check("prerst_valid", o_cmd_valid, 1);
    send_byte(8'hA5);
    i_rx = 1'b0;
    tick(3 * CPB);
    reset = 1'b1;
    i_rx = 1'b1;
    tick(3);
    check("midrst_valid", o_cmd_valid, 0);
    check("midrst_cmdarg", {o_cmd, o_arg}, 0);
    check("midrst_flags", {o_frame_err, o_chk_err, o_overrun, o_busy}, 0);
    reset = 1'b0;
    tick(2 * CPB);
    send_frame(8'h05, 8'h06, 8'h03);
    tick(4);
    check("postrst_valid", o_cmd_valid, 1);
    check("postrst_cmdarg", {o_cmd, o_arg}, 16'h0506);
    exp_q.push_back(16'h0506);
    ready_pulse();

    // randomized frames, consumer always ready
    i_cmd_ready = 1'b1;
    c0 = ce_cnt;
    o0 = ov_cnt;
    a0 = acc_cnt;
    exp_bad = 0;
    n_good = 0;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        do nb = 8'($urandom); while (nb == 8'hA5);
        send_byte(nb);
      end
      c = 8'($urandom);
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        k = c ^ a;
        exp_q.push_back({c, a});
        n_good++;
      end else begin
        k = c ^ a ^ 8'($urandom_range(1, 255));
        exp_bad++;
      end
      send_frame(c, a, k);
      tick($urandom_range(0, 3 * CPB));
    end
    tick(4);
    i_cmd_ready = 1'b0;
    check("rnd_chk_err", ce_cnt - c0, exp_bad);
    check("rnd_accepts", acc_cnt - a0, n_good);
    check("rnd_queue", exp_q.size(), 0);
    check("rnd_overrun", ov_cnt - o0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
